// File: rtl/decode_execute_stage.sv
// decode_execute_stage: ID + EX slice of a 5-stage MIPS-style pipeline
//   Register file with write-through, sign extension, ID/EX register, ALU + ALU control,
//   branch-target adder and EX/MEM register.
//   Ports:
//     clock, reset_n                       clock and asynchronous active-low reset
//     rs, rt, rd, shamt, funct, imm, pc4   IF/ID instruction fields
//     reg_dst..reg_write, alu_op           control from the hazard mux
//     idex_bubble                          zero the ID/EX control bits
//     wb_data, wb_reg, wb_we               write-back port into the register file
//     forward_a, forward_b                 EX operand selects (00 ID/EX, 10 EX/MEM, 01 wb_data)
//     idex_rs, idex_rt, idex_mem_read      ID/EX state for the forward/hazard units
//     exmem_*                              EX/MEM register towards the MEM stage
//   Configuration: EX_FORWARD_EN enables operand forwarding; without it the selects are ignored.
module decode_execute_stage #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [DATA_W-1:0] pc4,
  input  logic              reg_dst,
  input  logic              branch,
  input  logic              mem_read,
  input  logic              mem_to_reg,
  input  logic              mem_write,
  input  logic              alu_src,
  input  logic              reg_write,
  input  logic [1:0]        alu_op,
  input  logic              idex_bubble,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [4:0]        wb_reg,
  input  logic              wb_we,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  output logic [4:0]        idex_rs,
  output logic [4:0]        idex_rt,
  output logic              idex_mem_read,
  output logic [DATA_W-1:0] exmem_target,
  output logic [DATA_W-1:0] exmem_alu_result,
  output logic [DATA_W-1:0] exmem_store_data,
  output logic [4:0]        exmem_rd,
  output logic              exmem_zero,
  output logic              exmem_reg_write,
  output logic              exmem_branch,
  output logic              exmem_mem_read,
  output logic              exmem_mem_write,
  output logic              exmem_mem_to_reg
);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL
  } aluCtlT;

  logic [DATA_W-1:0] regFile [REG_N];
  logic [DATA_W-1:0] rsVal, rtVal, sextImm;

  logic [4:0]        idexRd, idexShamt;
  logic [5:0]        idexFunct;
  logic [DATA_W-1:0] idexImm, idexPc4, idexA, idexB;
  logic              idexRegDst, idexBranch, idexMemToReg, idexMemWrite, idexAluSrc, idexRegWrite;
  logic [1:0]        idexAluOp;

  logic [DATA_W-1:0] opA, fwdB, aluB, aluResult;
  aluCtlT            aluCtl;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_N; i++) regFile[i] <= '0;
    end else if (wb_we && wb_reg != 5'd0) begin
      regFile[wb_reg] <= wb_data;
    end
  end

  // A read of the register being written this cycle sees the new value.
  assign rsVal = (rs == 5'd0) ? '0 : (wb_we && wb_reg == rs) ? wb_data : regFile[rs];
  assign rtVal = (rt == 5'd0) ? '0 : (wb_we && wb_reg == rt) ? wb_data : regFile[rt];
  assign sextImm = {{(DATA_W-16){imm[15]}}, imm};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idex_rs       <= '0;
      idex_rt       <= '0;
      idexRd        <= '0;
      idexShamt     <= '0;
      idexFunct     <= '0;
      idexImm       <= '0;
      idexPc4       <= '0;
      idexA         <= '0;
      idexB         <= '0;
      idexRegDst    <= 1'b0;
      idexBranch    <= 1'b0;
      idex_mem_read <= 1'b0;
      idexMemToReg  <= 1'b0;
      idexMemWrite  <= 1'b0;
      idexAluSrc    <= 1'b0;
      idexRegWrite  <= 1'b0;
      idexAluOp     <= '0;
    end else begin
      idex_rs       <= rs;
      idex_rt       <= rt;
      idexRd        <= rd;
      idexShamt     <= shamt;
      idexFunct     <= funct;
      idexImm       <= sextImm;
      idexPc4       <= pc4;
      idexA         <= rsVal;
      idexB         <= rtVal;
      // A bubble keeps the data fields but kills every control bit.
      idexRegDst    <= idex_bubble ? 1'b0 : reg_dst;
      idexBranch    <= idex_bubble ? 1'b0 : branch;
      idex_mem_read <= idex_bubble ? 1'b0 : mem_read;
      idexMemToReg  <= idex_bubble ? 1'b0 : mem_to_reg;
      idexMemWrite  <= idex_bubble ? 1'b0 : mem_write;
      idexAluSrc    <= idex_bubble ? 1'b0 : alu_src;
      idexRegWrite  <= idex_bubble ? 1'b0 : reg_write;
      idexAluOp     <= idex_bubble ? 2'b00 : alu_op;
    end
  end

`ifdef EX_FORWARD_EN
  // Select 11 falls through to the ID/EX value.
  assign opA  = (forward_a == 2'b10) ? exmem_alu_result : (forward_a == 2'b01) ? wb_data : idexA;
  assign fwdB = (forward_b == 2'b10) ? exmem_alu_result : (forward_b == 2'b01) ? wb_data : idexB;
`else
  logic unusedFwd;
  assign unusedFwd = ^{forward_a, forward_b};
  assign opA  = idexA;
  assign fwdB = idexB;
`endif

  assign aluB = idexAluSrc ? idexImm : fwdB;

  always_comb begin
    aluCtl = ALU_ADD;
    case (idexAluOp)
      2'b01: aluCtl = ALU_SUB;
      2'b11: aluCtl = ALU_OR;
      2'b10: begin
        case (idexFunct)
          6'b100010: aluCtl = ALU_SUB;
          6'b100100: aluCtl = ALU_AND;
          6'b100101: aluCtl = ALU_OR;
          6'b101010: aluCtl = ALU_SLT;
          6'b000000: aluCtl = ALU_SLL;
          6'b000010: aluCtl = ALU_SRL;
          default:   aluCtl = ALU_ADD;
        endcase
      end
      default: aluCtl = ALU_ADD;
    endcase
  end

  always_comb begin
    aluResult = opA + aluB;
    case (aluCtl)
      ALU_SUB: aluResult = opA - aluB;
      ALU_AND: aluResult = opA & aluB;
      ALU_OR:  aluResult = opA | aluB;
      ALU_SLT: aluResult = {{(DATA_W-1){1'b0}}, $signed(opA) < $signed(aluB)};
      ALU_SLL: aluResult = aluB << idexShamt;
      ALU_SRL: aluResult = aluB >> idexShamt;
      default: aluResult = opA + aluB;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exmem_target     <= '0;
      exmem_alu_result <= '0;
      exmem_store_data <= '0;
      exmem_rd         <= '0;
      exmem_zero       <= 1'b0;
      exmem_reg_write  <= 1'b0;
      exmem_branch     <= 1'b0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
    end else begin
      exmem_target     <= idexPc4 + {idexImm[DATA_W-3:0], 2'b00};
      exmem_alu_result <= aluResult;
      exmem_store_data <= fwdB;
      exmem_rd         <= idexRegDst ? idexRd : idex_rt;
      exmem_zero       <= (aluResult == '0);
      exmem_reg_write  <= idexRegWrite;
      exmem_branch     <= idexBranch;
      exmem_mem_read   <= idex_mem_read;
      exmem_mem_write  <= idexMemWrite;
      exmem_mem_to_reg <= idexMemToReg;
    end
  end

endmodule

// File: tb/tb_decode_execute_stage.sv
// tb_decode_execute_stage: randomized + directed checks of decode_execute_stage against a transaction model
module tb_decode_execute_stage;

  logic        clock, reset_n;
  logic [4:0]  rs, rt, rd, shamt, wb_reg;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] pc4, wb_data;
  logic        reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [1:0]  alu_op, forward_a, forward_b;
  logic        idex_bubble, wb_we;
  logic [4:0]  idex_rs, idex_rt, exmem_rd;
  logic        idex_mem_read, exmem_zero, exmem_reg_write, exmem_branch;
  logic        exmem_mem_read, exmem_mem_write, exmem_mem_to_reg;
  logic [31:0] exmem_target, exmem_alu_result, exmem_store_data;

  decode_execute_stage dut (
    .clock(clock), .reset_n(reset_n),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .pc4(pc4),
    .reg_dst(reg_dst), .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op),
    .idex_bubble(idex_bubble), .wb_data(wb_data), .wb_reg(wb_reg), .wb_we(wb_we),
    .forward_a(forward_a), .forward_b(forward_b),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_mem_read(idex_mem_read),
    .exmem_target(exmem_target), .exmem_alu_result(exmem_alu_result),
    .exmem_store_data(exmem_store_data), .exmem_rd(exmem_rd), .exmem_zero(exmem_zero),
    .exmem_reg_write(exmem_reg_write), .exmem_branch(exmem_branch),
    .exmem_mem_read(exmem_mem_read), .exmem_mem_write(exmem_mem_write),
    .exmem_mem_to_reg(exmem_mem_to_reg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // A decoded instruction waiting in EX, and the result it leaves for MEM.
  typedef struct packed {
    logic [31:0] a, b, pc4, imm;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [1:0]  op;
    logic        regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite;
  } instrT;

  typedef struct packed {
    logic [31:0] target, alu, store;
    logic [4:0]  rd;
    logic        zero, regWrite, branch, memRead, memWrite, memToReg;
  } resultT;

  logic [31:0] regs [32];
  instrT       inEx;
  resultT      inMem;
  int          nCompared = 0;
  int          nMismatched = 0;
  logic [5:0]  functs [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] readReg(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_we && wb_reg == idx) return wb_data;
    return regs[idx];
  endfunction

  function automatic logic [31:0] aluRef(input logic [1:0] op, input logic [5:0] f,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] sh);
    if (op == 2'd1) return a - b;
    if (op == 2'd3) return a | b;
    if (op == 2'd0) return a + b;
    case (f)
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h2a:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h00:   return b << sh;
      6'h02:   return b >> sh;
      default: return a + b;
    endcase
  endfunction

  task automatic checkAll();
    check("target",    exmem_target,     inMem.target);
    check("alu",       exmem_alu_result, inMem.alu);
    check("store",     exmem_store_data, inMem.store);
    check("rd",        32'(exmem_rd),    32'(inMem.rd));
    check("zero",      32'(exmem_zero),  32'(inMem.zero));
    check("regwrite",  32'(exmem_reg_write),  32'(inMem.regWrite));
    check("branch",    32'(exmem_branch),     32'(inMem.branch));
    check("memread",   32'(exmem_mem_read),   32'(inMem.memRead));
    check("memwrite",  32'(exmem_mem_write),  32'(inMem.memWrite));
    check("memtoreg",  32'(exmem_mem_to_reg), 32'(inMem.memToReg));
    check("idex_rs",   32'(idex_rs),  32'(inEx.rs));
    check("idex_rt",   32'(idex_rt),  32'(inEx.rt));
    check("idex_mr",   32'(idex_mem_read), 32'(inEx.memRead));
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    inEx  = '0;
    inMem = '0;
  endtask

  // Advance the model by one edge using the inputs now applied, clock the DUT, compare.
  task automatic step();
    resultT nr;
    instrT  ni;
    logic [31:0] fa, fb, bb;
    fa = inEx.a;
    fb = inEx.b;
`ifdef EX_FORWARD_EN
    if (forward_a == 2'b10) fa = inMem.alu; else if (forward_a == 2'b01) fa = wb_data;
    if (forward_b == 2'b10) fb = inMem.alu; else if (forward_b == 2'b01) fb = wb_data;
`endif
    bb = inEx.aluSrc ? inEx.imm : fb;
    nr.alu      = aluRef(inEx.op, inEx.funct, fa, bb, inEx.shamt);
    nr.zero     = (nr.alu == 32'd0);
    nr.target   = inEx.pc4 + inEx.imm * 4;
    nr.store    = fb;
    nr.rd       = inEx.regDst ? inEx.rd : inEx.rt;
    nr.regWrite = inEx.regWrite;
    nr.branch   = inEx.branch;
    nr.memRead  = inEx.memRead;
    nr.memWrite = inEx.memWrite;
    nr.memToReg = inEx.memToReg;
    ni.a = readReg(rs);
    ni.b = readReg(rt);
    ni.pc4 = pc4;
    ni.imm = {{16{imm[15]}}, imm};
    ni.rs = rs; ni.rt = rt; ni.rd = rd; ni.shamt = shamt; ni.funct = funct;
    ni.op       = idex_bubble ? 2'b00 : alu_op;
    ni.regDst   = reg_dst    & ~idex_bubble;
    ni.branch   = branch     & ~idex_bubble;
    ni.memRead  = mem_read   & ~idex_bubble;
    ni.memToReg = mem_to_reg & ~idex_bubble;
    ni.memWrite = mem_write  & ~idex_bubble;
    ni.aluSrc   = alu_src    & ~idex_bubble;
    ni.regWrite = reg_write  & ~idex_bubble;
    if (wb_we && wb_reg != 5'd0) regs[wb_reg] = wb_data;
    inEx  = ni;
    inMem = nr;
    @(posedge clock);
    #1;
    checkAll();
  endtask

  task automatic idle();
    rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0; imm = '0; pc4 = '0;
    reg_dst = 0; branch = 0; mem_read = 0; mem_to_reg = 0; mem_write = 0;
    alu_src = 0; reg_write = 0; alu_op = '0; idex_bubble = 0;
    wb_data = '0; wb_reg = '0; wb_we = 0; forward_a = '0; forward_b = '0;
  endtask

  task automatic writeReg(input logic [4:0] idx, input logic [31:0] val);
    idle();
    wb_we = 1; wb_reg = idx; wb_data = val;
    step();
  endtask

  task automatic checkZeroOutputs(input string tag);
    check({tag, "_target"}, exmem_target, 32'd0);
    check({tag, "_alu"},    exmem_alu_result, 32'd0);
    check({tag, "_store"},  exmem_store_data, 32'd0);
    check({tag, "_ctl"}, 32'({exmem_rd, exmem_zero, exmem_reg_write, exmem_branch,
                              exmem_mem_read, exmem_mem_write, exmem_mem_to_reg}), 32'd0);
    check({tag, "_idex"}, 32'({idex_rs, idex_rt, idex_mem_read}), 32'd0);
  endtask

  task automatic randomInputs();
    rs = 5'($urandom_range(31)); rt = 5'($urandom_range(31)); rd = 5'($urandom_range(31));
    shamt = 5'($urandom_range(31));
    funct = ($urandom_range(7) == 0) ? 6'($urandom) : functs[$urandom_range(6)];
    imm = 16'($urandom); pc4 = $urandom;
    reg_dst = 1'($urandom); branch = 1'($urandom); mem_read = 1'($urandom);
    mem_to_reg = 1'($urandom); mem_write = 1'($urandom); alu_src = 1'($urandom);
    reg_write = 1'($urandom); alu_op = 2'($urandom);
    idex_bubble = ($urandom_range(7) == 0);
    wb_we = 1'($urandom);
    wb_reg = ($urandom_range(3) == 0) ? rs : 5'($urandom_range(31));
    wb_data = ($urandom_range(3) == 0) ? 32'($urandom_range(5)) : $urandom;
    forward_a = 2'($urandom); forward_b = 2'($urandom);
  endtask

  initial begin
    idle();
    reset_n = 0;
    modelReset();
    #12;
    checkZeroOutputs("rst_init");
    reset_n = 1;

    // R-type add
    writeReg(5'd1, 32'd5);
    writeReg(5'd2, 32'd7);
    idle(); rs = 5'd1; rt = 5'd2; rd = 5'd3; alu_op = 2'b10; funct = 6'b100000;
    reg_dst = 1; reg_write = 1;
    step();
    idle(); step();
    check("radd_alu", exmem_alu_result, 32'd12);
    check("radd_rd", 32'(exmem_rd), 32'd3);
    check("radd_zero", 32'(exmem_zero), 32'd0);

    // Branch compare and target
    writeReg(5'd1, 32'd9);
    writeReg(5'd2, 32'd9);
    idle(); rs = 5'd1; rt = 5'd2; alu_op = 2'b01; branch = 1; pc4 = 32'h100; imm = 16'hFFFF;
    step();
    idle(); step();
    check("br_alu", exmem_alu_result, 32'd0);
    check("br_zero", 32'(exmem_zero), 32'd1);
    check("br_target", exmem_target, 32'h0000_00FC);
    check("br_flag", 32'(exmem_branch), 32'd1);

    // Write-through bypass and r0
    idle(); wb_we = 1; wb_reg = 5'd4; wb_data = 32'hAA; rs = 5'd4;
    step();
    idle(); step();
    check("wt_alu", exmem_alu_result, 32'hAA);
    writeReg(5'd0, 32'h55);
    idle(); rs = 5'd0; rt = 5'd0; alu_op = 2'b11;
    step();
    idle(); step();
    check("r0_alu", exmem_alu_result, 32'd0);

`ifdef EX_FORWARD_EN
    // Back-to-back dependent add takes the previous EX/MEM result.
    idle(); rs = 5'd1; rt = 5'd2; alu_op = 2'b00;
    step();
    idle(); rs = 5'd0; rt = 5'd2; alu_op = 2'b00;
    step();
    check("fwd_first", exmem_alu_result, 32'd18);
    idle(); forward_a = 2'b10;
    step();
    check("fwd_a", exmem_alu_result, 32'd27);
    idle(); forward_b = 2'b01; wb_data = 32'd3;
    step();
    check("fwd_b", exmem_store_data, 32'd3);
`endif

    // Bubble on a load
    idle(); rs = 5'd1; rt = 5'd5; mem_read = 1; reg_write = 1; mem_to_reg = 1; alu_src = 1;
    imm = 16'd8; idex_bubble = 1;
    step();
    check("bub_idex_mr", 32'(idex_mem_read), 32'd0);
    idle(); step();
    check("bub_mr", 32'(exmem_mem_read), 32'd0);
    check("bub_rw", 32'(exmem_reg_write), 32'd0);

    // Same load without bubble carries its control through
    idle(); rs = 5'd1; rt = 5'd5; mem_read = 1; reg_write = 1; mem_to_reg = 1; alu_src = 1;
    imm = 16'd8;
    step();
    check("lw_idex_mr", 32'(idex_mem_read), 32'd1);
    idle(); step();
    check("lw_addr", exmem_alu_result, 32'd17);
    check("lw_mr", 32'(exmem_mem_read), 32'd1);

    for (int i = 0; i < 1500; i++) begin
      randomInputs();
      step();
      if (i == 700) begin
        reset_n = 0;
        #1;
        checkZeroOutputs("rst_mid");
        modelReset();
        @(posedge clock);
        #1;
        checkZeroOutputs("rst_hold");
        #2;
        reset_n = 1;
        idle(); rs = 5'd1; rt = 5'd2; alu_op = 2'b11;
        step();
        idle(); step();
        check("rst_read", exmem_alu_result, 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
